// File: rtl/timing_packet_rx.sv
// Receiver/parser for the 5-beat 64-bit eCPRI timing packet on the MAC RX stream.
// Validates the header, issues a one-cycle timing strobe on good packets, and counts ok/err/drop.
module timing_packet_rx #(
    parameter int          PACKET_LENGTH = 5,
    parameter logic [15:0] ETH_TYPE      = 16'hAEFE,
    parameter logic [15:0] VLAN_TPID     = 16'h8100,
    parameter logic [7:0]  MSG_TYPE      = 8'h02,
    parameter bit          ACCEPT_BCAST  = 1'b1,
    parameter int          CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      local_addr_l,
    input  logic [31:0]      local_addr_h,
    output logic             din_ready,
    input  logic             din_valid,
    input  logic             din_sop,
    input  logic             din_eop,
    input  logic [63:0]      din_data,
    input  logic [2:0]       din_empty,
    input  logic             din_error,
    output logic             timing_valid,
    output logic [15:0]      frame_index,
    output logic [15:0]      slot_index,
    output logic             ul_overflow,
    output logic             dl_overflow,
    output logic             dl_underflow,
    output logic             sync_status,
    output logic [7:0]       scs_cfg,
    output logic [CNT_W-1:0] rx_ok_cnt,
    output logic [CNT_W-1:0] rx_err_cnt,
    output logic [CNT_W-1:0] rx_drop_cnt
);

    localparam logic [2:0] LAST_IDX = 3'(PACKET_LENGTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_DROP} state_t;

    state_t           state_q, state_d;
    logic             din_ready_q;
    logic [2:0]       cnt_q, cnt_d;
    logic             hdr_bad_q, hdr_bad_d;
    logic             addr_miss_q, addr_miss_d;
    logic             mac_err_q, mac_err_d;
    logic [3:0]       sh_flags_q, sh_flags_d;
    logic [7:0]       sh_scs_q, sh_scs_d;
    logic             timing_valid_q, timing_valid_d;
    logic [15:0]      frame_q, frame_d;
    logic [15:0]      slot_q, slot_d;
    logic [3:0]       flags_q, flags_d;
    logic [7:0]       scs_q, scs_d;
    logic [CNT_W-1:0] ok_cnt_q, ok_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic        fire, new_pkt, in_pkt, abort;
    logic        last_beat, early_eop, overlen, final_beat;
    logic [2:0]  beat_idx;
    logic [47:0] local_mac;
    logic        beat_bad, beat_miss;
    logic        hdr_bad_now, addr_miss_now, mac_err_now;
    logic        eval_err, good, drop;
    logic [1:0]  err_inc;
    logic        unused_bits;

    assign local_mac   = {local_addr_h[15:0], local_addr_l};
    assign unused_bits = ^{local_addr_h[31:16], din_data[15:8]};

    // A sop beat always restarts parsing as b0, whatever state we are in
    assign fire       = din_valid & din_ready_q;
    assign new_pkt    = fire & din_sop;
    assign in_pkt     = new_pkt | (fire & (state_q == S_HDR));
    assign beat_idx   = new_pkt ? 3'd0 : cnt_q;
    assign abort      = new_pkt & (state_q == S_HDR);
    assign last_beat  = in_pkt & (beat_idx == LAST_IDX);
    assign early_eop  = in_pkt & din_eop & (beat_idx < LAST_IDX);
    assign overlen    = last_beat & ~din_eop;
    assign final_beat = last_beat & din_eop;

    always_comb begin
        beat_bad  = 1'b0;
        beat_miss = 1'b0;
        case (beat_idx)
            3'd0: beat_miss = (din_data[63:16] != local_mac) &&
                              !(ACCEPT_BCAST && (din_data[63:16] == 48'hFFFF_FFFF_FFFF));
            3'd1: beat_bad  = (din_data[31:16] != VLAN_TPID);
            3'd2: beat_bad  = (din_data[63:48] != ETH_TYPE) ||
                              (din_data[47:44] != 4'h1) ||
                              (din_data[39:32] != MSG_TYPE);
            default: ;
        endcase
    end

    // Sticky flags including the current beat, so the final beat's own checks count
    assign hdr_bad_now   = (hdr_bad_q & ~new_pkt) | beat_bad;
    assign addr_miss_now = (addr_miss_q & ~new_pkt) | beat_miss;
    assign mac_err_now   = (mac_err_q & ~new_pkt) | din_error;

    assign eval_err = final_beat & (mac_err_now | (din_empty != 3'd0) | hdr_bad_now);
    assign drop     = final_beat & ~eval_err & addr_miss_now;
    assign good     = final_beat & ~eval_err & ~addr_miss_now;
    assign err_inc  = {1'b0, abort} + {1'b0, early_eop | overlen | eval_err};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (in_pkt) begin
            if (din_eop)        state_d = S_IDLE;
            else if (last_beat) state_d = S_DROP;
            else                state_d = S_HDR;
        end else if (fire && din_eop && (state_q == S_DROP)) begin
            state_d = S_IDLE;
        end
    end

    always_comb begin
        cnt_d          = cnt_q;
        hdr_bad_d      = hdr_bad_q;
        addr_miss_d    = addr_miss_q;
        mac_err_d      = mac_err_q;
        sh_flags_d     = sh_flags_q;
        sh_scs_d       = sh_scs_q;
        timing_valid_d = good;
        frame_d        = frame_q;
        slot_d         = slot_q;
        flags_d        = flags_q;
        scs_d          = scs_q;
        ok_cnt_d       = ok_cnt_q + CNT_W'(good);
        drop_cnt_d     = drop_cnt_q + CNT_W'(drop);
        err_cnt_d      = err_cnt_q + CNT_W'(err_inc);
        if (in_pkt) begin
            cnt_d       = (din_eop || last_beat) ? 3'd0 : beat_idx + 3'd1;
            hdr_bad_d   = hdr_bad_now;
            addr_miss_d = addr_miss_now;
            mac_err_d   = mac_err_now;
            if (beat_idx == 3'd3) begin
                sh_flags_d = din_data[35:32];
                sh_scs_d   = din_data[7:0];
            end
        end
        // Frame/slot arrive on the final beat itself, so take them straight from the bus
        if (good) begin
            frame_d = din_data[63:48];
            slot_d  = din_data[47:32];
            flags_d = sh_flags_q;
            scs_d   = sh_scs_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_ready_q    <= 1'b0;
            cnt_q          <= 3'd0;
            hdr_bad_q      <= 1'b0;
            addr_miss_q    <= 1'b0;
            mac_err_q      <= 1'b0;
            sh_flags_q     <= 4'd0;
            sh_scs_q       <= 8'd0;
            timing_valid_q <= 1'b0;
            frame_q        <= 16'd0;
            slot_q         <= 16'd0;
            flags_q        <= 4'd0;
            scs_q          <= 8'd0;
            ok_cnt_q       <= '0;
            err_cnt_q      <= '0;
            drop_cnt_q     <= '0;
        end else begin
            din_ready_q    <= 1'b1;
            cnt_q          <= cnt_d;
            hdr_bad_q      <= hdr_bad_d;
            addr_miss_q    <= addr_miss_d;
            mac_err_q      <= mac_err_d;
            sh_flags_q     <= sh_flags_d;
            sh_scs_q       <= sh_scs_d;
            timing_valid_q <= timing_valid_d;
            frame_q        <= frame_d;
            slot_q         <= slot_d;
            flags_q        <= flags_d;
            scs_q          <= scs_d;
            ok_cnt_q       <= ok_cnt_d;
            err_cnt_q      <= err_cnt_d;
            drop_cnt_q     <= drop_cnt_d;
        end
    end

    assign din_ready    = din_ready_q;
    assign timing_valid = timing_valid_q;
    assign frame_index  = frame_q;
    assign slot_index   = slot_q;
    assign ul_overflow  = flags_q[3];
    assign dl_overflow  = flags_q[2];
    assign dl_underflow = flags_q[1];
    assign sync_status  = flags_q[0];
    assign scs_cfg      = scs_q;
    assign rx_ok_cnt    = ok_cnt_q;
    assign rx_err_cnt   = err_cnt_q;
    assign rx_drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_timing_packet_rx.sv
// Bench for timing_packet_rx: table of packet cases, hand sequences, and randomized
// traffic checked every cycle against a packet-level queue model.
module tb_timing_packet_rx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] local_addr_l = 32'h2233_4455;
    logic [31:0] local_addr_h = 32'hABCD_0011;
    logic        din_ready, din_valid, din_sop, din_eop, din_error;
    logic [63:0] din_data;
    logic [2:0]  din_empty;
    logic        timing_valid, ul_overflow, dl_overflow, dl_underflow, sync_status;
    logic [15:0] frame_index, slot_index, rx_ok_cnt, rx_err_cnt, rx_drop_cnt;
    logic [7:0]  scs_cfg;

    timing_packet_rx dut (
        .clk(clk), .rst_n(rst_n), .local_addr_l(local_addr_l), .local_addr_h(local_addr_h),
        .din_ready(din_ready), .din_valid(din_valid), .din_sop(din_sop), .din_eop(din_eop),
        .din_data(din_data), .din_empty(din_empty), .din_error(din_error),
        .timing_valid(timing_valid), .frame_index(frame_index), .slot_index(slot_index),
        .ul_overflow(ul_overflow), .dl_overflow(dl_overflow), .dl_underflow(dl_underflow),
        .sync_status(sync_status), .scs_cfg(scs_cfg),
        .rx_ok_cnt(rx_ok_cnt), .rx_err_cnt(rx_err_cnt), .rx_drop_cnt(rx_drop_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_tv = 0;

    localparam logic [47:0] MAC_LOCAL = 48'h0011_2233_4455;
    localparam logic [47:0] MAC_OTHER = 48'h0011_2233_4466;
    localparam logic [47:0] MAC_BCAST = 48'hFFFF_FFFF_FFFF;

    // Reference model: collect the beats of the packet in flight, judge it when it ends
    logic [63:0] m_q[$];
    bit          m_active, m_macerr;
    logic        e_tv, e_ready;
    logic [15:0] e_frame, e_slot, e_ok, e_err, e_drop;
    logic [3:0]  e_flags;
    logic [7:0]  e_scs;

    task automatic model_reset();
        m_q.delete();
        m_active = 0; m_macerr = 0;
        e_tv = 0; e_ready = 0; e_frame = 0; e_slot = 0;
        e_ok = 0; e_err = 0; e_drop = 0; e_flags = 0; e_scs = 0;
    endtask

    task automatic model_eval(input logic [2:0] emp);
        logic [47:0] dest;
        bit hdr_ok;
        dest   = m_q[0][63:16];
        hdr_ok = (m_q[1][31:16] == 16'h8100) && (m_q[2][63:48] == 16'hAEFE) &&
                 (m_q[2][47:44] == 4'h1) && (m_q[2][39:32] == 8'h02);
        if (m_macerr || emp != 0 || !hdr_ok) e_err++;
        else if (dest != {local_addr_h[15:0], local_addr_l} && dest != MAC_BCAST) e_drop++;
        else begin
            e_ok++;
            e_tv    = 1;
            e_flags = m_q[3][35:32];
            e_scs   = m_q[3][7:0];
            e_frame = m_q[4][63:48];
            e_slot  = m_q[4][47:32];
        end
    endtask

    task automatic model_step(input bit v, s, e, input logic [63:0] d,
                              input logic [2:0] emp, input bit er);
        e_tv = 0;
        if (v && e_ready) begin
            if (s) begin
                if (m_active) e_err++;
                m_active = 1; m_macerr = 0; m_q.delete();
            end
            if (m_active) begin
                m_q.push_back(d);
                m_macerr |= er;
                if (e) begin
                    if (m_q.size() < 5) e_err++;
                    else model_eval(emp);
                    m_active = 0;
                end else if (m_q.size() == 5) begin
                    e_err++;
                    m_active = 0;
                end
            end
        end
        e_ready = 1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("din_ready", din_ready, e_ready);
        chk("timing_valid", timing_valid, e_tv);
        chk("frame_index", frame_index, e_frame);
        chk("slot_index", slot_index, e_slot);
        chk("flags", {ul_overflow, dl_overflow, dl_underflow, sync_status}, e_flags);
        chk("scs_cfg", scs_cfg, e_scs);
        chk("rx_ok_cnt", rx_ok_cnt, e_ok);
        chk("rx_err_cnt", rx_err_cnt, e_err);
        chk("rx_drop_cnt", rx_drop_cnt, e_drop);
    endtask

    task automatic beat(input bit v, s, e, input logic [63:0] d,
                        input logic [2:0] emp, input bit er);
        din_valid = v; din_sop = s; din_eop = e; din_data = d;
        din_empty = emp; din_error = er;
        @(posedge clk);
        if (rst_n) model_step(v, s, e, d, emp, er);
        #1;
        check_all();
        if (timing_valid === 1'b1) n_tv++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) beat(0, 0, 0, 64'h0, 3'd0, 0);
    endtask

    // corrupt: 0 none, 1 TPID, 2 version nibble, 3 message type
    task automatic send_pkt(input logic [47:0] dest, input logic [15:0] etype,
                            input logic [15:0] frame, input logic [15:0] slot,
                            input logic [3:0] flags, input logic [7:0] scs, input int len,
                            input bit noeop, input int err_beat, input logic [2:0] emp,
                            input int corrupt, input bit gaps);
        logic [63:0] b[5];
        b[0] = {dest, 16'h0066};
        b[1] = {32'h0, 16'h8100, 16'h0001};
        b[2] = {etype, 4'h1, 4'h0, 8'h02, 32'h0};
        b[3] = {28'h0, flags, 24'h0, scs};
        b[4] = {frame, slot, 32'h0};
        if (corrupt == 1) b[1][31:16] = 16'h88A8;
        if (corrupt == 2) b[2][47:44] = 4'h2;
        if (corrupt == 3) b[2][39:32] = 8'h03;
        for (int i = 0; i < len; i++) begin
            logic [63:0] d;
            bit last;
            if (gaps && $urandom_range(0, 3) == 0) idle(1);
            d    = (i < 5) ? b[i] : {$urandom, $urandom};
            last = (i == len - 1) && !noeop;
            beat(1, i == 0, last, d, last ? emp : 3'd0, i == err_beat);
        end
    endtask

    typedef struct {
        string       name;
        logic [47:0] dest;
        logic [15:0] etype;
        logic [15:0] frame;
        logic [15:0] slot;
        logic [3:0]  flags;
        int          len;
        int          err_beat;
        logic [2:0]  emp;
        int          d_ok, d_err, d_drop, strobes;
    } vec_t;

    function automatic vec_t mk(input string nm, input logic [47:0] dest,
                                input logic [15:0] et, input logic [15:0] fr,
                                input logic [15:0] sl, input logic [3:0] fl, input int len,
                                input int eb, input logic [2:0] emp,
                                input int dok, input int derr, input int ddrop);
        vec_t v;
        v.name = nm; v.dest = dest; v.etype = et; v.frame = fr; v.slot = sl; v.flags = fl;
        v.len = len; v.err_beat = eb; v.emp = emp;
        v.d_ok = dok; v.d_err = derr; v.d_drop = ddrop; v.strobes = dok;
        return v;
    endfunction

    initial begin
        vec_t tbl[8];
        logic [15:0] b_ok, b_err, b_drop, b_frame, b_slot;

        tbl[0] = mk("good",     MAC_LOCAL, 16'hAEFE, 16'h0123, 16'h0007, 4'b1000, 5, -1, 3'd0, 1, 0, 0);
        tbl[1] = mk("ethtype",  MAC_LOCAL, 16'h0800, 16'h0555, 16'h0008, 4'b0001, 5, -1, 3'd0, 0, 1, 0);
        tbl[2] = mk("addrmiss", MAC_OTHER, 16'hAEFE, 16'h0666, 16'h0009, 4'b0010, 5, -1, 3'd0, 0, 0, 1);
        tbl[3] = mk("bcast",    MAC_BCAST, 16'hAEFE, 16'h0124, 16'h000A, 4'b0101, 5, -1, 3'd0, 1, 0, 0);
        tbl[4] = mk("early",    MAC_LOCAL, 16'hAEFE, 16'h0777, 16'h000B, 4'b1111, 3, -1, 3'd0, 0, 1, 0);
        tbl[5] = mk("long",     MAC_LOCAL, 16'hAEFE, 16'h0888, 16'h000C, 4'b1111, 7, -1, 3'd0, 0, 1, 0);
        tbl[6] = mk("macerr",   MAC_LOCAL, 16'hAEFE, 16'h0999, 16'h000D, 4'b1111, 5,  1, 3'd0, 0, 1, 0);
        tbl[7] = mk("empty",    MAC_LOCAL, 16'hAEFE, 16'h0AAA, 16'h000E, 4'b1111, 5, -1, 3'd3, 0, 1, 0);

        din_valid = 0; din_sop = 0; din_eop = 0; din_data = 0; din_empty = 0; din_error = 0;
        model_reset();
        #1;
        check_all();
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        idle(2);

        // Stray non-sop beats while idle are ignored
        beat(1, 0, 1, 64'hDEAD_BEEF_0000_0000, 3'd0, 0);
        idle(1);

        foreach (tbl[k]) begin
            b_ok = e_ok; b_err = e_err; b_drop = e_drop; b_frame = e_frame; b_slot = e_slot;
            n_tv = 0;
            send_pkt(tbl[k].dest, tbl[k].etype, tbl[k].frame, tbl[k].slot, tbl[k].flags,
                     8'h5A, tbl[k].len, 0, tbl[k].err_beat, tbl[k].emp, 0, 0);
            idle(2);
            chk({tbl[k].name, "_strobes"}, n_tv, tbl[k].strobes);
            chk({tbl[k].name, "_ok"}, rx_ok_cnt, b_ok + 16'(tbl[k].d_ok));
            chk({tbl[k].name, "_err"}, rx_err_cnt, b_err + 16'(tbl[k].d_err));
            chk({tbl[k].name, "_drop"}, rx_drop_cnt, b_drop + 16'(tbl[k].d_drop));
            chk({tbl[k].name, "_frame"}, frame_index, tbl[k].strobes != 0 ? tbl[k].frame : b_frame);
            chk({tbl[k].name, "_slot"}, slot_index, tbl[k].strobes != 0 ? tbl[k].slot : b_slot);
        end

        // Packet cut short by a new sop on its fourth beat
        b_ok = e_ok; b_err = e_err;
        send_pkt(MAC_LOCAL, 16'hAEFE, 16'h0BBB, 16'h0011, 4'b0000, 8'h11, 3, 1, -1, 3'd0, 0, 0);
        send_pkt(MAC_LOCAL, 16'hAEFE, 16'h0CCC, 16'h0012, 4'b0100, 8'h22, 5, 0, -1, 3'd0, 0, 0);
        idle(1);
        chk("abort_err", rx_err_cnt, b_err + 16'd1);
        chk("abort_ok", rx_ok_cnt, b_ok + 16'd1);
        chk("abort_frame", frame_index, 16'h0CCC);

        // Ten back-to-back good packets
        n_tv = 0;
        for (int s = 0; s < 10; s++)
            send_pkt(MAC_LOCAL, 16'hAEFE, 16'h1000, 16'(s), 4'b0001, 8'h03, 5, 0, -1, 3'd0, 0, 0);
        idle(1);
        chk("b2b_strobes", n_tv, 10);
        chk("b2b_slot", slot_index, 16'd9);

        // Asynchronous reset in the middle of beat 2
        beat(1, 1, 0, {MAC_LOCAL, 16'h0}, 3'd0, 0);
        beat(1, 0, 0, {32'h0, 16'h8100, 16'h0}, 3'd0, 0);
        din_data = {16'hAEFE, 4'h1, 4'h0, 8'h02, 32'h0};
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("rst_ok", rx_ok_cnt, 16'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(2);
        send_pkt(MAC_LOCAL, 16'hAEFE, 16'h0321, 16'h0004, 4'b1000, 8'h01, 5, 0, -1, 3'd0, 0, 0);
        idle(1);
        chk("post_rst_ok", rx_ok_cnt, 16'd1);

        // Randomized traffic against the model
        for (int p = 0; p < 300; p++) begin
            logic [47:0] dest;
            int r, len, eb, cor;
            bit noeop;
            logic [2:0] emp;
            r     = $urandom_range(0, 9);
            dest  = (r == 0) ? MAC_OTHER : (r == 1) ? MAC_BCAST :
                    (r == 2) ? {$urandom, 16'h1234} : MAC_LOCAL;
            len   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 5;
            noeop = ($urandom_range(0, 9) == 0);
            eb    = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 4) : -1;
            emp   = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            cor   = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
            send_pkt(dest, ($urandom_range(0, 9) == 0) ? 16'h0800 : 16'hAEFE,
                     16'($urandom), 16'($urandom), 4'($urandom), 8'($urandom),
                     len, noeop, eb, emp, cor, 1);
            if ($urandom_range(0, 5) == 0)
                beat(1, 0, $urandom_range(0, 1) == 1, {$urandom, $urandom}, 3'd0, 0);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
        end
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/timing_packet_rx.md
Name: timing_packet_rx

Overview:
Receiver and parser for the 5-beat, 64-bit Avalon-ST eCPRI timing packet produced by the timing packet transmitter on the MAC TX path. It sits on the MAC RX Avalon-ST stream. It validates the Ethernet/VLAN/eCPRI header and extracts frame index, slot index and status flags. On a good packet it issues a one-cycle timing strobe to the local timing logic and maintains ok/error/drop counters.

Parameters:
PACKET_LENGTH, 5, beats per timing packet (layout fixed for 5)
ETH_TYPE, 16'hAEFE, required EtherType
VLAN_TPID, 16'h8100, required TPID
MSG_TYPE, 8'h02, required eCPRI message type
ACCEPT_BCAST, 1, 1 = also accept dest MAC FF:FF:FF:FF:FF:FF
CNT_W, 16, counter width

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
local_addr_l  in  32  local MAC [31:0]
local_addr_h  in  32  local MAC [47:32] in bits [15:0]; [31:16] ignored
din_ready  out  1  stream ready
din_valid  in  1  beat valid
din_sop  in  1  start of packet
din_eop  in  1  end of packet
din_data  in  64  beat data
din_empty  in  3  empty bytes on eop beat
din_error  in  1  MAC error flag
timing_valid  out  1  1-cycle strobe, good packet received
frame_index  out  16  last good frame index
slot_index  out  16  last good slot index
ul_overflow, dl_overflow, dl_underflow, sync_status  out  1 each  flags from last good packet
scs_cfg  out  8  subcarrier spacing config from last good packet
rx_ok_cnt, rx_err_cnt, rx_drop_cnt  out  CNT_W each  packet counters

Behaviour:
- Reset: all outputs 0, including din_ready. FSM goes to IDLE. The beat counter and shadow registers clear. Reset mid-packet discards the packet without counting it.
- din_ready: registered. Goes 1 on the first clk after reset release and stays 1. There is no backpressure. A beat is consumed when din_valid & din_ready.
- Beat layout, checked per beat into a sticky hdr_bad flag:
  - b0: [63:16] dest MAC, must equal local MAC (or broadcast if ACCEPT_BCAST); mismatch sets addr_miss. [15:0] source MAC hi, ignored.
  - b1: [31:16] must equal VLAN_TPID. Rest ignored.
  - b2: [63:48] must equal ETH_TYPE. [47:44] must be 4'h1. [39:32] must equal MSG_TYPE.
  - b3: ul_overflow=[35], dl_overflow=[34], dl_underflow=[33], sync_status=[32], scs=[7:0]; captured to shadow registers.
  - b4: frame_index=[63:48], slot_index=[47:32]; captured to shadow registers.
- FSM states:
  - IDLE: a beat with sop → check b0, beat counter=1, go to HDR. A beat without sop is ignored and not counted.
  - HDR: each beat increments the counter.
  - Beat with sop in HDR: the current packet is aborted and counted in rx_err_cnt. This beat is treated as a new b0 and the FSM stays in HDR.
  - Early eop (counter < PACKET_LENGTH-1): rx_err_cnt+1, go to IDLE.
  - Beat PACKET_LENGTH-1 without eop: rx_err_cnt+1, go to DROP.
  - Beat PACKET_LENGTH-1 with eop: evaluate the packet.
  - DROP: discard beats until eop, then go to IDLE. A sop in DROP starts a new packet, as in IDLE.
- Evaluation at the final beat, in priority order:
  - din_error on any beat, or din_empty≠0 on the eop beat, or hdr_bad → rx_err_cnt+1.
  - Else addr_miss → rx_drop_cnt+1.
  - Else good: rx_ok_cnt+1. Shadow registers copy to the outputs and timing_valid=1 on the next cycle.
- Latency: timing_valid and updated outputs appear 1 cycle after the eop beat is consumed. Outputs hold until the next good packet. Bad packets never alter them.
- Exactly one counter increments per packet terminated by eop, abort, or overlength. Counters wrap modulo 2^CNT_W.
- Back-to-back packets (sop on the cycle after eop) are fully supported.

Test Plan:
1. local MAC 00:11:22:33:44:55; send a good packet with frame=16'h0123, slot=16'h0007, ul_overflow=1 → timing_valid pulse 1 cycle after eop; frame_index=0x0123, slot_index=0x0007, ul_overflow=1; rx_ok_cnt=1.
2. Same packet with EtherType 16'h0800 → no strobe; rx_err_cnt=1; outputs keep the previous values.
3. Dest MAC 00:11:22:33:44:66 → rx_drop_cnt=1. Dest MAC FF:FF:FF:FF:FF:FF → accepted (rx_ok_cnt+1).
4. eop on beat 2 → rx_err_cnt+1. 7-beat packet → rx_err_cnt+1 and the extra beats are ignored. sop on beat 3 followed by a good 5-beat packet → rx_err_cnt+1 then rx_ok_cnt+1.
5. Good packet with din_error=1 on beat 1, or din_empty=3 on eop → rx_err_cnt+1, no strobe.
6. Ten back-to-back good packets with slot 0..9 → ten strobes, slot_index ends at 9. Assert rst_n low during beat 2 → all outputs and counters 0; the next good packet gives rx_ok_cnt=1.
